// File: rtl/uart_button_tx_if.sv
// Signal bundle between a button/byte source and the UART frame transmitter.
interface uart_button_tx_if;
    logic       transmit;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output transmit, output data, input tx, input busy, input done);
    modport slave  (input transmit, input data, output tx, output busy, output done);
endinterface

// File: rtl/uart_button_tx.sv
// Sends one 8N1 (optionally even-parity) UART frame per rising edge of a debounced button level.
module uart_button_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int PARITY_EN    = 0
) (
    input logic           clk,
    input logic           rst,
    uart_button_tx_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_reg_next;
    logic             transmit_q;
    logic             request;
    logic             bit_end;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    assign request = bus.transmit & ~transmit_q;
    assign bit_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            transmit_q <= 1'b1;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_reg_next;
            transmit_q <= bus.transmit;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;

        if (state == IDLE) begin
            if (request) begin
                state_next     = START;
                shift_reg_next = bus.data;
                baud_cnt_next  = '0;
                bit_idx_next   = '0;
            end
        end else if (bit_end) begin
            baud_cnt_next = '0;
            case (state)
                START:  state_next = DATA;
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        if (PARITY_EN != 0) state_next = PARITY;
                        else                state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
                PARITY: state_next = STOP;
                default: state_next = IDLE;
            endcase
        end else begin
            baud_cnt_next = baud_cnt + 1'b1;
        end

        // Outputs are precomputed from the next state so tx/busy/done come straight from flops.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg_next[bit_idx_next];
            PARITY:  tx_next = ^shift_reg_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (baud_cnt_next == CNT_LAST);
    end

    assign bus.tx   = tx_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_uart_button_tx.sv
// Directed bench for uart_button_tx: one DUT without parity, one with even parity, CLKS_PER_BIT = 4.
module tb_uart_button_tx;
    localparam int N = 4;
    localparam int W = 256;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic tx_s   [W];
    logic busy_s [W];
    logic done_s [W];

    uart_button_tx_if bus0 ();
    uart_button_tx_if bus1 ();

    uart_button_tx #(.CLKS_PER_BIT(N), .PARITY_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_button_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_transmit(input int sel, input logic v);
        if (sel != 0) bus1.transmit = v;
        else          bus0.transmit = v;
    endtask

    task automatic set_data(input int sel, input logic [7:0] d);
        if (sel != 0) bus1.data = d;
        else          bus0.data = d;
    endtask

    // Samples ncyc cycles at negedge; transmit/data events are applied right after the sample at that index.
    task automatic sample(input int sel, input int ncyc, input int up0, input int dn0, input int up1,
                          input int chg_at, input logic [7:0] chg_data);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            tx_s[i]   = (sel != 0) ? bus1.tx   : bus0.tx;
            busy_s[i] = (sel != 0) ? bus1.busy : bus0.busy;
            done_s[i] = (sel != 0) ? bus1.done : bus0.done;
            if (i == dn0) set_transmit(sel, 1'b0);
            if (i == up0 || i == up1) set_transmit(sel, 1'b1);
            if (i == chg_at) set_data(sel, chg_data);
        end
    endtask

    function automatic int cnt_busy(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (busy_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (done_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_txlow(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (tx_s[i] !== 1'b1) c++;
        return c;
    endfunction

    function automatic int first_busy(input int lo);
        for (int i = lo; i < W; i++) if (busy_s[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int first_done(input int lo);
        for (int i = lo; i < W; i++) if (done_s[i] === 1'b1) return i;
        return -1;
    endfunction

    // Number of cycles whose tx differs from frame bit (i / N), frame given LSB = start bit.
    function automatic int frame_err(input int start, input logic [10:0] f, input int nbits);
        int c = 0;
        for (int i = 0; i < nbits * N; i++) if (tx_s[start + i] !== f[i / N]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus0.transmit = 1'b0; bus0.data = 8'h00;
        bus1.transmit = 1'b0; bus1.data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",    bus0.tx,   1);
        check("rst_busy",  bus0.busy, 0);
        check("rst_done",  bus0.done, 0);
        check("rst_tx_p",  bus1.tx,   1);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame 0xA5; data changed mid-frame must not matter
        bus0.data = 8'hA5;
        sample(0, 50, 0, -1, -1, 3, 8'h00);
        check("basic_first_busy", first_busy(0), 1);
        check("basic_busy_len",   cnt_busy(0, 49), 40);
        check("basic_done_cnt",   cnt_done(0, 49), 1);
        check("basic_done_at",    first_done(0), 40);
        check("basic_frame",      frame_err(1, 11'h34A, 10), 0);
        check("basic_idle_after", {busy_s[41], tx_s[41]}, 2'b01);
        set_transmit(0, 1'b0);
        repeat (2) @(posedge clk);

        // Parity frames
        bus1.data = 8'h07;
        sample(1, 50, 0, -1, -1, -1, 8'h00);
        check("par07_busy_len", cnt_busy(0, 49), 44);
        check("par07_done_at",  first_done(0), 44);
        check("par07_frame",    frame_err(1, 11'h60E, 11), 0);
        set_transmit(1, 1'b0);
        repeat (2) @(posedge clk);
        bus1.data = 8'h03;
        sample(1, 50, 0, -1, -1, -1, 8'h00);
        check("par03_frame",    frame_err(1, 11'h406, 11), 0);
        check("par03_done_cnt", cnt_done(0, 49), 1);
        set_transmit(1, 1'b0);
        repeat (2) @(posedge clk);

        // Held level: one frame only
        bus0.data = 8'h3C;
        sample(0, 100, 0, -1, -1, -1, 8'h00);
        check("held_done_cnt", cnt_done(0, 99), 1);
        check("held_busy_len", cnt_busy(0, 99), 40);
        check("held_frame",    frame_err(1, 11'h278, 10), 0);
        set_transmit(0, 1'b0);
        repeat (2) @(posedge clk);

        // Second edge while busy is dropped
        bus0.data = 8'h5A;
        sample(0, 100, 0, 10, 12, -1, 8'h00);
        check("retrig_done_cnt", cnt_done(0, 99), 1);
        check("retrig_busy_len", cnt_busy(0, 99), 40);
        check("retrig_frame",    frame_err(1, 11'h2B4, 10), 0);
        set_transmit(0, 1'b0);
        repeat (2) @(posedge clk);

        // Back-to-back: request in first IDLE cycle after done
        bus0.data = 8'hA5;
        sample(0, 100, 0, 5, 41, 41, 8'h81);
        check("b2b_done1_at",   first_done(0), 40);
        check("b2b_gap_busy",   busy_s[41], 0);
        check("b2b_start2_at",  first_busy(41), 42);
        check("b2b_frame2",     frame_err(42, 11'h302, 10), 0);
        check("b2b_done2_at",   first_done(41), 81);
        check("b2b_done_cnt",   cnt_done(0, 99), 2);
        set_transmit(0, 1'b0);
        repeat (2) @(posedge clk);

        // Mid-frame reset during data bit 3 (tx low there for 0x00)
        bus0.data = 8'h00;
        sample(0, 19, 0, -1, -1, -1, 8'h00);
        check("mid_pre_tx",   tx_s[18], 0);
        check("mid_pre_busy", busy_s[18], 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx",   bus0.tx,   1);
        check("mid_rst_busy", bus0.busy, 0);
        check("mid_rst_done", bus0.done, 0);
        set_transmit(0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus0.data = 8'h96;
        sample(0, 60, 5, -1, -1, -1, 8'h00);
        check("mid_no_done",    cnt_done(0, 5), 0);
        check("mid_new_start",  first_busy(0), 6);
        check("mid_new_frame",  frame_err(6, 11'h32C, 10), 0);
        check("mid_new_done",   first_done(0), 45);

        // transmit high through reset must not start a frame
        set_transmit(0, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus0.data = 8'hC3;
        sample(0, 120, 62, 60, -1, -1, 8'h00);
        check("rsthi_no_busy", cnt_busy(0, 60), 0);
        check("rsthi_tx_idle", cnt_txlow(0, 60), 0);
        check("rsthi_start",   first_busy(0), 63);
        check("rsthi_frame",   frame_err(63, 11'h386, 10), 0);
        check("rsthi_done",    cnt_done(0, 119), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
